// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM state encoding, the opcodes the
// hazard unit decodes, and the widths of the sequencing and event counters.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } ctrl_state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Sequencing counter holds at most STALL_CYCLES-1 = 3.
  localparam int CNT_W  = 2;
  // Width of the hazard event counters.
  localparam int STAT_W = 16;

  // Only R-type, store and branch instructions actually read rs2.
  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Load-use register match: flags when the load in ID/EX writes a register
// that the instruction in IF/ID reads. x0 never creates a dependency.
module hazard_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [6:0] id_opcode,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       hazard
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = (ex_rd == id_rs1);
  assign rs2_hit = (ex_rd == id_rs2) && uses_rs2(id_opcode);
  assign hazard  = ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls on load-use hazards, flushes IF/ID after
// taken branches, and optionally counts both events.
// Optional feature: define HAZARD_STATS_EN to build the saturating event
// counters; otherwise stall_count and flush_count are tied to zero.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_CYCLES = 1,  // load-use stall length, 1..4
  parameter int FLUSH_CYCLES = 1   // IF/ID flush length after a taken branch, 1..3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [6:0]        id_opcode,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rd,
  input  logic              branch_taken,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic [1:0]        state,
  output logic [STAT_W-1:0] stall_count,
  output logic [STAT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'(STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

  ctrl_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             hazard;

  hazard_cmp u_cmp (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_opcode   (id_opcode),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .hazard      (hazard)
  );

  // Same-cycle pipeline controls: reset forces free-run, then branch beats
  // FLUSH, which beats stall.
  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves
    // one unassigned, which would otherwise infer a latch.
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (!rst) begin
      if (branch_taken || state_q == ST_FLUSH) begin
        id_ex_bubble = 1'b1;
        if_id_flush  = 1'b1;
      end else if (state_q == ST_STALL || hazard) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end
  end

  // Sequencing FSM: a counter measures the remaining STALL or FLUSH cycles.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only; while rst is high the
    // combinational block above already forces the free-run controls.
    if (rst) begin
      // NOTE: non-blocking assignments keep every register updating from the
      // pre-edge values, independent of statement order.
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else if (branch_taken) begin
      // A taken branch aborts any stall and (re)starts the flush sequence.
      if (FLUSH_CYCLES > 1) begin
        state_q <= ST_FLUSH;
        cnt_q   <= FLUSH_LOAD;
      end else begin
        state_q <= ST_RUN;
        cnt_q   <= '0;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hazard && STALL_CYCLES > 1) begin
            state_q <= ST_STALL;
            cnt_q   <= STALL_LOAD;
          end
        end
        ST_STALL: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_q <= ST_RUN;
        end
        ST_FLUSH: begin
          if (cnt_q == '0) state_q <= ST_RUN;
          else             cnt_q   <= cnt_q - CNT_ONE;
        end
        default: begin
          state_q <= ST_RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign state = state_q;

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q;
  logic [STAT_W-1:0] flush_cnt_q;
  logic              stall_bubble;

  // A bubble without a flush can only come from a load-use hazard.
  assign stall_bubble = id_ex_bubble && !if_id_flush;

  // Saturating event counters: hazard bubble cycles and taken branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_bubble && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (branch_taken && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (STALL/FLUSH = 1/1, 3/2, 4/3) share
// one set of inputs. A vector table covers single-cycle decoding on the 1/1
// instance; hand-written sequences cover the multi-cycle corners.
// Build with HAZARD_STATS_EN defined to exercise the event counters.
module tb_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam logic [6:0] OP_IMM = 7'b0010011;

  // {pc_write, if_id_write, id_ex_bubble, if_id_flush, state[1:0]}
  typedef logic [5:0] outs_t;
  localparam outs_t E_RUN      = 6'b1100_00;
  localparam outs_t E_STALL_R  = 6'b0010_00;  // hazard seen in RUN
  localparam outs_t E_STALL_S  = 6'b0010_01;  // held in STALL
  localparam outs_t E_BR_R     = 6'b1111_00;  // branch seen in RUN
  localparam outs_t E_BR_S     = 6'b1111_01;  // branch seen in STALL
  localparam outs_t E_FLUSH    = 6'b1111_10;  // in FLUSH
  localparam outs_t E_RST_S    = 6'b1100_01;  // rst high while STALL registered
  localparam outs_t E_RST_F    = 6'b1100_10;  // rst high while FLUSH registered

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic [6:0] id_opcode;
  logic       ex_mem_read, branch_taken;

  logic        pc1, ifw1, bub1, fl1, pc3, ifw3, bub3, fl3, pc4, ifw4, bub4, fl4;
  logic [1:0]  st1, st3, st4;
  logic [15:0] sc1, fc1, sc3, fc3, sc4, fc4;
  outs_t       o1, o3, o4;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.STALL_CYCLES(1), .FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_opcode(id_opcode),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .pc_write(pc1), .if_id_write(ifw1), .id_ex_bubble(bub1), .if_id_flush(fl1),
    .state(st1), .stall_count(sc1), .flush_count(fc1));

  hazard_ctrl #(.STALL_CYCLES(3), .FLUSH_CYCLES(2)) dut3 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_opcode(id_opcode),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .pc_write(pc3), .if_id_write(ifw3), .id_ex_bubble(bub3), .if_id_flush(fl3),
    .state(st3), .stall_count(sc3), .flush_count(fc3));

  hazard_ctrl #(.STALL_CYCLES(4), .FLUSH_CYCLES(3)) dut4 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_opcode(id_opcode),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .pc_write(pc4), .if_id_write(ifw4), .id_ex_bubble(bub4), .if_id_flush(fl4),
    .state(st4), .stall_count(sc4), .flush_count(fc4));

  assign o1 = {pc1, ifw1, bub1, fl1, st1};
  assign o3 = {pc3, ifw3, bub3, fl3, st3};
  assign o4 = {pc4, ifw4, bub4, fl4, st4};

  typedef struct {
    string      name;
    logic       r;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] op;
    logic       mr;
    logic [4:0] rd;
    logic       bt;
    outs_t      exp;
  } vec_t;

  vec_t vt[14];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [6:0] op, input logic mr, input logic [4:0] rd,
                       input logic bt);
    rst = r; id_rs1 = rs1; id_rs2 = rs2; id_opcode = op;
    ex_mem_read = mr; ex_rd = rd; branch_taken = bt;
  endtask

  task automatic idle();       apply(1'b0, 5'd1, 5'd2, OP_R, 1'b0, 5'd9, 1'b0); endtask
  task automatic hazard_in();  apply(1'b0, 5'd5, 5'd2, OP_R, 1'b1, 5'd5, 1'b0); endtask
  task automatic branch_in();  apply(1'b0, 5'd1, 5'd2, OP_R, 1'b0, 5'd9, 1'b1); endtask

  // Outputs are sampled mid-cycle; inputs change just after the rising edge.
  task automatic sample();  @(negedge clk);       endtask
  task automatic advance(); @(posedge clk); #1;   endtask

  task automatic do_reset();
    apply(1'b1, 5'd5, 5'd2, OP_R, 1'b1, 5'd5, 1'b0);
    sample();
    advance();
  endtask

  initial begin
    //        name          rst   rs1    rs2    op         mr    rd     bt    exp (dut1)
    vt[0]  = '{"rst_forced",  1'b1, 5'd5,  5'd0,  OP_R,      1'b1, 5'd5,  1'b0, E_RUN};
    vt[1]  = '{"rs1_hit",     1'b0, 5'd5,  5'd0,  OP_R,      1'b1, 5'd5,  1'b0, E_STALL_R};
    vt[2]  = '{"after_stall", 1'b0, 5'd6,  5'd0,  OP_R,      1'b1, 5'd5,  1'b0, E_RUN};
    vt[3]  = '{"x0_no_haz",   1'b0, 5'd0,  5'd3,  OP_R,      1'b1, 5'd0,  1'b0, E_RUN};
    vt[4]  = '{"rs2_imm",     1'b0, 5'd1,  5'd7,  OP_IMM,    1'b1, 5'd7,  1'b0, E_RUN};
    vt[5]  = '{"rs2_r",       1'b0, 5'd1,  5'd7,  OP_R,      1'b1, 5'd7,  1'b0, E_STALL_R};
    vt[6]  = '{"rs2_store",   1'b0, 5'd1,  5'd7,  OP_STORE,  1'b1, 5'd7,  1'b0, E_STALL_R};
    vt[7]  = '{"rs2_branch",  1'b0, 5'd1,  5'd7,  OP_BRANCH, 1'b1, 5'd7,  1'b0, E_STALL_R};
    vt[8]  = '{"rs2_load",    1'b0, 5'd1,  5'd7,  OP_LOAD,   1'b1, 5'd7,  1'b0, E_RUN};
    vt[9]  = '{"no_load",     1'b0, 5'd5,  5'd5,  OP_R,      1'b0, 5'd5,  1'b0, E_RUN};
    vt[10] = '{"br_and_haz",  1'b0, 5'd5,  5'd0,  OP_R,      1'b1, 5'd5,  1'b1, E_BR_R};
    vt[11] = '{"br_only",     1'b0, 5'd1,  5'd2,  OP_R,      1'b0, 5'd9,  1'b1, E_BR_R};
    vt[12] = '{"rst_over_br", 1'b1, 5'd5,  5'd0,  OP_R,      1'b1, 5'd5,  1'b1, E_RUN};
    vt[13] = '{"idle",        1'b0, 5'd1,  5'd2,  OP_R,      1'b0, 5'd9,  1'b0, E_RUN};

    // Single-cycle decoding on the STALL_CYCLES=1, FLUSH_CYCLES=1 instance.
    for (int i = 0; i < 14; i++) begin
      apply(vt[i].r, vt[i].rs1, vt[i].rs2, vt[i].op, vt[i].mr, vt[i].rd, vt[i].bt);
      sample();
      check(vt[i].name, 16'(o1), 16'(vt[i].exp));
      advance();
    end

    // Three-cycle stall: bubble for N..N+2, STALL for N+1..N+2, RUN at N+3.
    do_reset();
    hazard_in(); sample();
    check("s3_n",   16'(o3), 16'(E_STALL_R));
    advance();
    idle(); sample();
    check("s3_n1",  16'(o3), 16'(E_STALL_S));
    check("s1_run", 16'(o1), 16'(E_RUN));
    advance(); sample();
    check("s3_n2",  16'(o3), 16'(E_STALL_S));
    advance(); sample();
    check("s3_n3",  16'(o3), 16'(E_RUN));
    advance();

    // Branch beats hazard; two flush cycles; hazard ignored during FLUSH.
    do_reset();
    apply(1'b0, 5'd5, 5'd2, OP_R, 1'b1, 5'd5, 1'b1); sample();
    check("f2_n",  16'(o3), 16'(E_BR_R));
    advance();
    hazard_in(); sample();
    check("f2_n1", 16'(o3), 16'(E_FLUSH));
    advance();
    idle(); sample();
    check("f2_n2", 16'(o3), 16'(E_RUN));
    check("f2_no_stall_cnt", sc3, 16'd0);
`ifdef HAZARD_STATS_EN
    check("f2_flush_cnt", fc3, 16'd1);
`else
    check("f2_flush_cnt", fc3, 16'd0);
`endif
    advance();

    // Branch during STALL aborts the stall.
    do_reset();
    hazard_in(); sample();
    check("ab_n", 16'(o3), 16'(E_STALL_R));
    advance();
    branch_in(); sample();
    check("ab_br", 16'(o3), 16'(E_BR_S));
    advance();
    idle(); sample();
    check("ab_flush", 16'(o3), 16'(E_FLUSH));
    advance(); sample();
    check("ab_run", 16'(o3), 16'(E_RUN));
    advance();

    // Reset in the middle of a four-cycle stall.
    do_reset();
    hazard_in(); sample(); advance();
    idle(); sample();
    check("rs_stall", 16'(o4), 16'(E_STALL_S));
    advance();
    apply(1'b1, 5'd5, 5'd2, OP_R, 1'b1, 5'd5, 1'b0); sample();
    check("rs_forced", 16'(o4), 16'(E_RST_S));
    advance();
    idle(); sample();
    check("rs_run0", 16'(o4), 16'(E_RUN));
    advance(); sample();
    check("rs_run1", 16'(o4), 16'(E_RUN));
    advance();

    // Three-cycle flush restarted by a second branch, then reset mid-flush.
    do_reset();
    branch_in(); sample();
    check("fr_n", 16'(o4), 16'(E_BR_R));
    advance();
    idle(); sample();
    check("fr_n1", 16'(o4), 16'(E_FLUSH));
    advance();
    branch_in(); sample();
    check("fr_rebr", 16'(o4), 16'(E_FLUSH));
    advance();
    idle(); sample();
    check("fr_n3", 16'(o4), 16'(E_FLUSH));
    advance(); sample();
    check("fr_n4", 16'(o4), 16'(E_FLUSH));
    advance(); sample();
    check("fr_run", 16'(o4), 16'(E_RUN));
    advance();
    branch_in(); sample(); advance();
    apply(1'b1, 5'd1, 5'd2, OP_R, 1'b0, 5'd9, 1'b0); sample();
    check("fr_rst", 16'(o4), 16'(E_RST_F));
    advance();
    idle(); sample();
    check("fr_rst_run", 16'(o4), 16'(E_RUN));
    advance();

    // Event counters: three hazards and two branches.
    do_reset();
    hazard_in(); sample(); advance();
    idle();      sample(); advance();
    hazard_in(); sample(); advance();
    idle();      sample(); advance();
    hazard_in(); sample(); advance();
    branch_in(); sample(); advance();
    idle();      sample(); advance();
    branch_in(); sample(); advance();
    idle();      sample();
`ifdef HAZARD_STATS_EN
    check("stat_stall", sc1, 16'd3);
    check("stat_flush", fc1, 16'd2);
`else
    check("stat_stall_off", sc1, 16'd0);
    check("stat_flush_off", fc1, 16'd0);
    check("stat_s4_off",    sc4, 16'd0);
    check("stat_f4_off",    fc4, 16'd0);
`endif
    advance();

`ifdef HAZARD_STATS_EN
    // Hold a hazard long enough to pass 16'hFFFF bubble cycles.
    do_reset();
    hazard_in();
    repeat (65540) advance();
    sample();
    check("stat_sat",     sc1, 16'hFFFF);
    check("stat_sat_fc",  fc1, 16'd0);
    advance();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter STALL_CYCLES, default 1, meaning load-use stall length in cycles (legal 1..4).
REQ-002 SHALL have parameter FLUSH_CYCLES, default 1, meaning cycles the IF/ID register is flushed after a taken branch (legal 1..3).
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port id_rs1  input  5  rs1 field of the instruction held in IF/ID.
REQ-006 SHALL have port id_rs2  input  5  rs2 field of the instruction held in IF/ID.
REQ-007 SHALL have port id_opcode  input  7  opcode held in IF/ID.
REQ-008 SHALL have port ex_mem_read  input  1  instruction in ID/EX is a load.
REQ-009 SHALL have port ex_rd  input  5  destination register of the ID/EX instruction.
REQ-010 SHALL have port branch_taken  input  1  one-cycle pulse meaning the branch resolved taken.
REQ-011 SHALL have port pc_write  output  1  PC update enable.
REQ-012 SHALL have port if_id_write  output  1  IF/ID load enable.
REQ-013 SHALL have port id_ex_bubble  output  1  zeroes the ID/EX control field.
REQ-014 SHALL have port if_id_flush  output  1  drives the IF/ID flush (PCsrc) input.
REQ-015 SHALL have port state  output  2  current FSM state: RUN=0, STALL=1, FLUSH=2.
REQ-016 SHALL have ports stall_count and flush_count  output  16 each  event counters (see Configuration).

Function
REQ-017 SHALL detect a hazard combinationally when ex_mem_read=1 and ex_rd!=0 and ex_rd equals id_rs1, or equals id_rs2 for opcodes 0110011, 0100011 and 1100011 only.
REQ-018 SHALL, in RUN with a hazard and no branch_taken, drive pc_write=0, if_id_write=0 and id_ex_bubble=1 in the same cycle.
REQ-019 SHALL, in that case, enter STALL with a counter loaded to STALL_CYCLES-1 when STALL_CYCLES>1, and otherwise stay in RUN.
REQ-020 SHALL, in STALL, hold pc_write=0, if_id_write=0 and id_ex_bubble=1, decrement the counter, and return to RUN on the cycle the counter reads 0.
REQ-021 SHALL give branch_taken priority over a hazard in every state: that cycle drives if_id_flush=1, pc_write=1, id_ex_bubble=1 and if_id_write=1.
REQ-022 SHALL, on branch_taken, enter FLUSH when FLUSH_CYCLES>1 with a counter loaded to FLUSH_CYCLES-2, and otherwise stay in RUN.
REQ-023 SHALL, on branch_taken during STALL, abort the remaining stall immediately.
REQ-024 SHALL, in FLUSH, drive if_id_flush=1 and id_ex_bubble=1, ignore hazards, and return to RUN after the counter reaches 0.
REQ-025 SHALL restart the flush count from FLUSH_CYCLES-2 when branch_taken arrives while already in FLUSH.
REQ-026 SHALL, in RUN with neither a hazard nor branch_taken, drive pc_write=1, if_id_write=1, id_ex_bubble=0 and if_id_flush=0.

Reset
REQ-027 SHALL, while rst=1 at a clock edge, set state=RUN, internal counters=0, stall_count=0 and flush_count=0.
REQ-028 SHALL, while rst=1, force pc_write=1, if_id_write=1, id_ex_bubble=0 and if_id_flush=0 regardless of inputs.
REQ-029 SHALL, on reset asserted mid-STALL or mid-FLUSH, abandon the sequence with no residual stall or flush cycles after rst falls.

Configuration
REQ-030 SHALL, with macro HAZARD_STATS_EN defined, increment stall_count once per cycle with id_ex_bubble=1 from a hazard and flush_count once per branch_taken pulse, both saturating at 16'hFFFF.
REQ-031 SHALL, without HAZARD_STATS_EN, keep both ports present and tie them to 0 with no counter logic.

Structure
REQ-032 SHALL place the state enumeration, the opcode constants (R 0110011, LOAD 0000011, STORE 0100011, BRANCH 1100011) and the counter width in shared package pipe_ctrl_pkg.
REQ-033 SHALL put the register-match comparison of REQ-017 in sub-module hazard_cmp, instantiated once.

Verification
REQ-034 SHALL cover: ex_mem_read=1, ex_rd=5, id_rs1=5, id_opcode=0110011, STALL_CYCLES=1 -> exactly one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1, then RUN.
REQ-035 SHALL cover: ex_rd=0, id_rs1=0 with ex_mem_read=1 -> no stall; ex_rd=7, id_rs2=7, opcode 0010011 -> no stall.
REQ-036 SHALL cover: STALL_CYCLES=3 with a hazard in cycle N -> bubble held for N..N+2, state=STALL for N+1..N+2, RUN at N+3.
REQ-037 SHALL cover: branch_taken together with a hazard -> if_id_flush=1, pc_write=1, no stall counted; with FLUSH_CYCLES=2, flush is asserted for exactly 2 cycles.
REQ-038 SHALL cover: rst asserted in the middle of STALL_CYCLES=4 -> all outputs at reset values at the next edge and RUN after release.
REQ-039 SHALL cover: with HAZARD_STATS_EN, 3 hazards and 2 branches -> stall_count=3 and flush_count=2; with stall_count preloaded near 16'hFFFF it saturates at 16'hFFFF.
